ahb_dma_copy_master: RTL and testbench

- Single-channel AHB-lite bus master that copies a block of 32-bit words from a source address to a destination address, one word at a time (read, then write).
- Sits directly upstream of the test SRAM slave: it drives the SRAM's HADDR/HWRITE/HWDATA and consumes its HRDATA/HREADY.
- Used by the testbench and the core subsystem to preload or move memory images without CPU involvement.

---
 rtl/ahb_dma_copy_master.sv | 164 ++++++++++++++++
 tb/tb_ahb_dma_copy_master.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_dma_copy_master.sv
// Single-channel AHB-lite copy engine: moves len_words 32-bit words from src to dst,
// one NONSEQ read followed by one NONSEQ write per word, in ascending address order.
module ahb_dma_copy_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len_words,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_D = 3'd2,
    S_WR_A = 3'd3,
    S_WR_D = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam logic [1:0]        TRANS_IDLE   = 2'b00;
  localparam logic [1:0]        TRANS_NONSEQ = 2'b10;
  localparam logic [ADDR_W-1:0] WORD_MASK    = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] WORD_STEP    = ADDR_W'(4);

  state_t              state;
  logic [ADDR_W-1:0]   src_ptr;
  logic [ADDR_W-1:0]   dst_ptr;
  logic [LEN_W-1:0]    cnt;
  logic [DATA_W-1:0]   rd_buf;

  assign HSIZE = 3'b010;

  // Outputs are assigned on the edge that enters each state, so every bus
  // signal comes straight from a flop and holds through HREADY wait states.
  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the values sampled before the clock edge.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      HADDR   <= '0;
      HTRANS  <= TRANS_IDLE;
      HWRITE  <= 1'b0;
      HWDATA  <= '0;
      src_ptr <= '0;
      dst_ptr <= '0;
      cnt     <= '0;
      rd_buf  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            err  <= 1'b0;
            busy <= 1'b1;
            if (len_words != '0) begin
              src_ptr <= src_addr & WORD_MASK;
              dst_ptr <= dst_addr & WORD_MASK;
              cnt     <= len_words;
              HADDR   <= src_addr & WORD_MASK;
              HTRANS  <= TRANS_NONSEQ;
              HWRITE  <= 1'b0;
              state   <= S_RD_A;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end

        S_RD_A: begin
          if (HREADY) begin
            HTRANS <= TRANS_IDLE;
            state  <= S_RD_D;
          end
        end

        S_RD_D: begin
          if (HREADY) begin
            if (HRESP) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= S_ERR;
            end else begin
              rd_buf <= HRDATA;
              HADDR  <= dst_ptr;
              HTRANS <= TRANS_NONSEQ;
              HWRITE <= 1'b1;
              state  <= S_WR_A;
            end
          end
        end

        S_WR_A: begin
          if (HREADY) begin
            HTRANS <= TRANS_IDLE;
            HWDATA <= rd_buf;
            state  <= S_WR_D;
          end
        end

        S_WR_D: begin
          if (HREADY) begin
            HWRITE <= 1'b0;
            if (HRESP) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= S_ERR;
            end else begin
              src_ptr <= src_ptr + WORD_STEP;
              dst_ptr <= dst_ptr + WORD_STEP;
              cnt     <= cnt - LEN_W'(1);
              if (cnt == LEN_W'(1)) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                HADDR  <= src_ptr + WORD_STEP;
                HTRANS <= TRANS_NONSEQ;
                state  <= S_RD_A;
              end
            end
          end
        end

        S_DONE, S_ERR: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Protocol sanity properties; synthesis ignores them.
  a_htrans_legal: assert property (@(posedge HCLK) disable iff (!HRESETn)
    (HTRANS == TRANS_IDLE) || (HTRANS == TRANS_NONSEQ));

  a_done_single: assert property (@(posedge HCLK) disable iff (!HRESETn)
    done |=> !done);

  a_wdata_stable: assert property (@(posedge HCLK) disable iff (!HRESETn)
    (state == S_WR_D && !HREADY) |=> $stable(HWDATA));

endmodule

// File: tb/tb_ahb_dma_copy_master.sv
// Bench for ahb_dma_copy_master: AHB slave memory model with planned wait states and
// error injection, a word-level copy reference model, and queue-based scoreboards.
module tb_ahb_dma_copy_master;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  logic              HCLK = 1'b0;
  logic              HRESETn = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0;
  logic [ADDR_W-1:0] dst_addr = '0;
  logic [LEN_W-1:0]  len_words = '0;
  logic              busy, done, err;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA = '0;
  logic              HREADY = 1'b1;
  logic              HRESP = 1'b0;

  ahb_dma_copy_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len_words(len_words), .busy(busy), .done(done), .err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int unsigned c0;
    int unsigned off;
    logic        err;
    int unsigned xfers;
  } exp_done_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_wr_t;

  exp_done_t   exp_q[$];
  exp_wr_t     wr_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] mem     [bit [31:0]];
  logic [31:0] ref_mem [bit [31:0]];
  int          waits[$];
  int          err_phase = -1;
  int          phase_idx = 0;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    mem[a]     = d;
    ref_mem[a] = d;
  endtask

  initial forever begin
    @(posedge HCLK);
    cyc++;
  end

  // AHB slave: decides HREADY/HRESP at the negedge for the edge that follows.
  initial begin : slave
    bit          dp_active = 1'b0;
    bit          dp_first = 1'b0;
    bit          dp_write = 1'b0;
    int          dp_wait = 0;
    logic [31:0] dp_addr = '0;
    logic [65:0] snap = '0;
    exp_wr_t     e;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        dp_active = 1'b0;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
      end else begin
        if (dp_active) begin
          if (dp_first) begin
            snap     = {HADDR, HTRANS, HWDATA};
            dp_first = 1'b0;
          end else begin
            check("wait_stable", {HADDR, HTRANS, HWDATA}, snap);
          end
          if (dp_wait > 0) begin
            HREADY = 1'b0;
            HRESP  = 1'b0;
            dp_wait--;
          end else begin
            HREADY = 1'b1;
            HRESP  = (phase_idx == err_phase);
            if (!dp_write) begin
              check("rd_expected", rd_q.size() != 0, 1);
              if (rd_q.size() != 0) check("rd_addr", dp_addr, rd_q.pop_front());
              HRDATA = HRESP ? 32'hDEAD_BEEF : mem_rd(dp_addr);
            end else if (!HRESP) begin
              check("wr_expected", wr_q.size() != 0, 1);
              if (wr_q.size() != 0) begin
                e = wr_q.pop_front();
                check("wr_addr_data", {dp_addr, HWDATA}, {e.addr, e.data});
              end
              mem[dp_addr] = HWDATA;
            end
            phase_idx++;
            dp_active = 1'b0;
          end
        end else begin
          HREADY = 1'b1;
          HRESP  = 1'b0;
        end
        if (HTRANS == 2'b10 && HREADY) begin
          dp_active = 1'b1;
          dp_first  = 1'b1;
          dp_addr   = HADDR;
          dp_write  = HWRITE;
          dp_wait   = (phase_idx < waits.size()) ? waits[phase_idx] : 0;
        end
      end
    end
  end

  // Completion monitor: pops one expectation per done pulse.
  initial begin : monitor
    int unsigned busy_run = 0;
    int unsigned xfer_run = 0;
    exp_done_t   e;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        busy_run = 0;
        xfer_run = 0;
      end else begin
        if (busy) busy_run++;
        if (HTRANS == 2'b10) xfer_run++;
        if (done) begin
          check("done_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("done_cycle", cyc - e.c0, e.off);
            check("done_err", err, e.err);
            check("busy_cycles", busy_run, e.off);
            check("bus_xfers", xfer_run, e.xfers);
          end
          busy_run = 0;
          xfer_run = 0;
        end
      end
    end
  end

  // Word-level reference: reads src+4i, writes dst+4i in ascending order, stops on the
  // faulting phase (phase 2i = read of word i, 2i+1 = write of word i).
  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input int ep, input int rd_w, input int wr_w,
                          input int abort_at, input bit restart);
    logic [31:0] s, d, ra, wa, data;
    logic [31:0] pre_addr[$];
    logic [31:0] pre_val[$];
    bit          pre_ex[$];
    int unsigned sum, xfers, c0, off, completed;
    bit          werr;
    s = src & ~32'h3;
    d = dst & ~32'h3;
    sum = 0;
    xfers = 0;
    werr = 1'b0;
    waits.delete();
    for (int p = 0; p < 2 * len; p++) begin
      if (p % 2 == 0) waits.push_back(rd_w < 0 ? int'($urandom_range(0, 2)) : rd_w);
      else            waits.push_back(wr_w < 0 ? int'($urandom_range(0, 2)) : wr_w);
    end
    for (int i = 0; i < len; i++) begin
      ra = s + 32'(4 * i);
      wa = d + 32'(4 * i);
      rd_q.push_back(ra);
      sum += waits[2*i];
      xfers++;
      if (ep == 2 * i) begin werr = 1'b1; break; end
      data = ref_rd(ra);
      sum += waits[2*i+1];
      xfers++;
      if (ep == 2 * i + 1) begin werr = 1'b1; break; end
      pre_addr.push_back(wa);
      pre_ex.push_back(ref_mem.exists(wa));
      pre_val.push_back(ref_rd(wa));
      wr_q.push_back('{wa, data});
      ref_mem[wa] = data;
    end
    off = werr ? 32'(2 * ep + 3) + sum : 32'(4 * len + 1) + sum;
    err_phase = ep;
    phase_idx = 0;

    @(negedge HCLK);
    start     = 1'b1;
    src_addr  = src;
    dst_addr  = dst;
    len_words = LEN_W'(len);
    c0        = cyc;
    if (abort_at == 0) exp_q.push_back('{c0, off, werr, xfers});
    @(negedge HCLK);
    start     = 1'b0;
    src_addr  = $urandom;
    dst_addr  = $urandom;
    len_words = LEN_W'($urandom_range(0, 7));

    if (restart) begin
      repeat (2) @(negedge HCLK);
      start     = 1'b1;
      len_words = LEN_W'($urandom_range(1, 5));
      @(negedge HCLK);
      start = 1'b0;
    end

    if (abort_at != 0) begin
      while (cyc < c0 + 32'(abort_at)) @(negedge HCLK);
      #2 HRESETn = 1'b0;
      #1 check("async_reset_outputs", {busy, done, err, HTRANS, HWRITE, HADDR, HWDATA}, 128'(0));
      completed = 32'((abort_at - 1) / 4);
      check("abort_pending_writes", wr_q.size(), 32'(len) - completed);
      for (int k = int'(completed); k < pre_addr.size(); k++) begin
        if (pre_ex[k]) ref_mem[pre_addr[k]] = pre_val[k];
        else           ref_mem.delete(pre_addr[k]);
      end
      wr_q.delete();
      rd_q.delete();
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;
      @(negedge HCLK);
      check("idle_after_abort", {busy, done, HTRANS}, 128'(0));
    end else begin
      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge HCLK);
      check("done_seen", exp_q.size(), 0);
      exp_q.delete();
      @(negedge HCLK);
      check("post_busy", busy, 0);
      check("post_err_sticky", err, werr);
      check("queues_drained", {wr_q.size(), rd_q.size()}, 128'(0));
      wr_q.delete();
      rd_q.delete();
    end
    repeat ($urandom_range(0, 2)) @(negedge HCLK);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [31:0] s, d;
    int          len, ep;
    repeat (3) @(negedge HCLK);
    check("reset_outputs", {busy, done, err, HTRANS, HWRITE, HADDR, HWDATA}, 128'(0));
    check("hsize_word", HSIZE, 3'b010);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);

    // Directed: basic copy, zero length, read waits, read error then err clear.
    poke(32'h100, 32'hA1);
    poke(32'h104, 32'hB2);
    poke(32'h108, 32'hC3);
    run_copy(32'h100, 32'h200, 3, -1, 0, 0, 0, 1'b0);
    run_copy(32'h140, 32'h240, 0, -1, 0, 0, 0, 1'b0);
    run_copy(32'h300, 32'h400, 2, -1, 2, 0, 0, 1'b0);
    run_copy(32'h500, 32'h600, 4, 2, 0, 0, 0, 1'b0);
    run_copy(32'h700, 32'h800, 2, -1, 0, 0, 0, 1'b1);
    // Reset in cycle 6, then a clean rerun; then address wrap with unaligned input.
    run_copy(32'h900, 32'hA00, 3, -1, 0, 0, 6, 1'b0);
    run_copy(32'h900, 32'hA00, 3, -1, 0, 0, 0, 1'b0);
    poke(32'hFFFF_FFFC, 32'h1111_2222);
    poke(32'h0000_0000, 32'h3333_4444);
    run_copy(32'hFFFF_FFFE, 32'hB01, 2, -1, 0, 0, 0, 1'b0);

    // Randomized copies over a small region so source and destination overlap.
    for (int t = 0; t < 25; t++) begin
      len = $urandom_range(1, 8);
      s   = 32'h1000 + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
      d   = 32'h1000 + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
      ep  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * len - 1)) : -1;
      run_copy(s, d, len, ep, -1, -1, 0, 1'b0);
    end

    check("mem_entries", mem.size(), ref_mem.size());
    foreach (ref_mem[a]) begin
      check("mem_word", {mem.exists(a), mem_rd(a)}, {1'b1, ref_mem[a]});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
